data_bus_responder: RTL and testbench
=====================================

# data_bus_responder

Memory-side responder for the core's data bus: terminates the data-read channel (dr_*) and the data-write channel (dw_*) that the core drives as initiator. It holds a word-addressed SRAM, returns read data, commits writes and issues a write response code. It is used as the data memory in simulation top levels and in FPGA builds, and sits directly on the core's dr_*/dw_* ports.

## Interface
- DEPTH, 1024: number of 32-bit words; must be a power of two.
- LATENCY, 2: extra wait cycles before read data or write response. Used only with DATA_BUS_RESPONDER_LATENCY_EN.
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; asynchronous, active-low.
- dr_addr_valid  in  1  read address valid.
- dr_addr  in  BUS_WIDTH  read byte address.
- dr_addr_ready  out  1  read address accepted.
- dr_data_valid  out  1  read data valid.
- dr_data  out  BUS_WIDTH  read data.
- dr_data_ready  in  1  core accepts read data.
- dw_data_addr_valid  in  1  write address and data valid.
- dw_addr  in  BUS_WIDTH  write byte address.
- dw_data  in  BUS_WIDTH  write data.
- dw_data_addr_ready  out  1  write accepted.
- dw_resp_valid  out  1  write response valid.
- dw_resp  out  BUS_RESP_WIDTH  DATA_WRITE_RESP_OK or DATA_WRITE_RESP_FAIL.
- dw_resp_ready  in  1  core accepts response.

## Operation
- A transfer occurs on a channel when its valid and ready are both high on a rising clk edge.
- Word index is addr[2 +: log2(DEPTH)].
  - An address is in range iff addr >> 2 < DEPTH.
  - A write also requires addr[1:0] == 0.
  - A read ignores addr[1:0].
- Read FSM has three states: R_IDLE, R_WAIT, R_DATA.
  - R_IDLE: dr_addr_ready=1. On an address transfer, latch the word index and go to R_WAIT when the latency counter is non-zero, otherwise go to R_DATA.
  - R_WAIT: count down the latency counter, then go to R_DATA.
  - R_DATA: dr_data_valid=1. dr_data holds the memory word, or 0 when the address is out of range. dr_data stays stable until dr_data_ready. On the data transfer, go to R_IDLE.
  - dr_addr_ready=0 outside R_IDLE: one read outstanding at most.
- Write FSM has three states: W_IDLE, W_WAIT, W_RESP.
  - W_IDLE: dw_data_addr_ready=1. On a transfer, write the memory on that same edge if the address is in range and aligned. Latch resp = OK in that case, else FAIL and no write. Go to W_WAIT or W_RESP, under the same rule as the read FSM.
  - W_RESP: dw_resp_valid=1 and dw_resp is held stable until dw_resp_ready. On the response transfer, go to W_IDLE.
- The two channels are independent and may be active in the same cycle.
  - A read and a write accepted on the same edge to the same word: the read returns the old data.
  - A later read returns the new data.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset (rst low, asynchronous):
  - Both FSMs go to IDLE.
  - All outputs go to 0: readies, valids, dr_data and dw_resp (dw_resp = 0 means FAIL, with valid low).
  - The latency counters clear.
- Ready outputs are registered. dr_addr_ready and dw_data_addr_ready rise on the first clk edge after rst goes high.
- Without the macro:
  - Read: address transfer at edge N, dr_data_valid high after edge N+1.
  - Write: transfer at N, dw_resp_valid high after N+1.
  - With ready held high, the next address is accepted at N+2. Throughput is one transaction per 2 cycles per channel.
- With the macro: LATENCY extra cycles are spent in R_WAIT/W_WAIT. LATENCY=0 behaves exactly like the build without the macro.
- Valid, once raised, never drops before the matching transfer.
- Reset asserted mid-transaction:
  - The transaction is abandoned and no response is issued.
  - A write already accepted stays committed to memory.

## Configuration
- DATA_BUS_RESPONDER_LATENCY_EN
  - Defined: includes the wait states and a per-channel down-counter of width clog2(LATENCY+1), loaded with LATENCY on each accepted address.
  - Undefined: there are no wait states or counters. The FSMs go directly from IDLE to R_DATA/W_RESP, and the LATENCY parameter is ignored.

## Structure
- BUS_WIDTH, BUS_RESP_WIDTH, DATA_WRITE_RESP_OK/FAIL and the FSM state encodings live in the shared header copperv_h.v.
- Sub-module responder_mem holds the storage array:
  - one synchronous write port;
  - one synchronous read port;
  - read data registered, old data on a same-address read/write;
  - DEPTH parameter.

## Test plan
- Write then read: write 0xCAFEBABE to 0x10, response OK; read 0x10, dr_data=0xCAFEBABE, valid one cycle after the address transfer (macro off).
- Out of range: with DEPTH=1024, write 0x1000 gives FAIL and memory is unchanged; read 0x1000 returns 0.
- Misaligned: write to 0x13 gives FAIL; read of 0x13 returns the word at 0x10.
- Backpressure: hold dr_data_ready=0 and dw_resp_ready=0 for 5 cycles. Valid and data stay stable and readies stay 0; the transfer completes when ready rises.
- Collision: read and write of 0x20 on the same edge (old value 0x1, new 0x2). The read returns 0x1 and a following read returns 0x2.
- Latency and reset: with the macro and LATENCY=3, dr_data_valid rises 4 cycles after the address transfer. Asserting rst during R_WAIT drops all outputs to 0 immediately; after release, readies return at the first edge.

Source files
------------

// File: rtl/data_bus_responder_pkg.sv
// Shared bus widths, write response codes, FSM encodings and address helpers
// for the data-bus responder.
package data_bus_responder_pkg;

    localparam int unsigned BUS_WIDTH      = 32;
    localparam int unsigned BUS_RESP_WIDTH = 1;
    localparam int unsigned ADDR_CMP_W     = BUS_WIDTH + 2;

    localparam logic [BUS_RESP_WIDTH-1:0] DATA_WRITE_RESP_OK   = 1'b1;
    localparam logic [BUS_RESP_WIDTH-1:0] DATA_WRITE_RESP_FAIL = 1'b0;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } read_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } write_state_t;

    typedef struct packed {
        logic [BUS_WIDTH-1:0] addr;
        logic [BUS_WIDTH-1:0] data;
    } dw_req_t;

    // Byte address maps to a word below depth; widened so 4*depth cannot overflow.
    function automatic logic addr_in_range(input logic [BUS_WIDTH-1:0] addr,
                                           input int unsigned depth);
        return {2'b00, addr} < (ADDR_CMP_W'(depth) << 2);
    endfunction

endpackage

// File: rtl/data_bus_responder_if.sv
// Core data-bus channels: data read (dr_*) and data write (dw_*).
interface data_bus_responder_if;
    import data_bus_responder_pkg::*;

    logic                      dr_addr_valid;
    logic [BUS_WIDTH-1:0]      dr_addr;
    logic                      dr_addr_ready;
    logic                      dr_data_valid;
    logic [BUS_WIDTH-1:0]      dr_data;
    logic                      dr_data_ready;

    logic                      dw_data_addr_valid;
    logic [BUS_WIDTH-1:0]      dw_addr;
    logic [BUS_WIDTH-1:0]      dw_data;
    logic                      dw_data_addr_ready;
    logic                      dw_resp_valid;
    logic [BUS_RESP_WIDTH-1:0] dw_resp;
    logic                      dw_resp_ready;

    modport master (
        output dr_addr_valid, dr_addr, dr_data_ready,
        input  dr_addr_ready, dr_data_valid, dr_data,
        output dw_data_addr_valid, dw_addr, dw_data, dw_resp_ready,
        input  dw_data_addr_ready, dw_resp_valid, dw_resp
    );

    modport slave (
        input  dr_addr_valid, dr_addr, dr_data_ready,
        output dr_addr_ready, dr_data_valid, dr_data,
        input  dw_data_addr_valid, dw_addr, dw_data, dw_resp_ready,
        output dw_data_addr_ready, dw_resp_valid, dw_resp
    );

endinterface

// File: rtl/data_bus_responder_mem.sv
// Word SRAM with one synchronous write port and one registered read port;
// a same-word read and write on one edge returns the old word.
module data_bus_responder_mem #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic                     rd_zero,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Read register holds its word until the next accepted read; rd_zero masks out-of-range reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_zero ? '0 : mem[rd_idx];
        end
    end

endmodule

// File: rtl/data_bus_responder.sv
// Memory-side responder for the core's dr_*/dw_* channels backed by a word SRAM.
// Define DATA_BUS_RESPONDER_LATENCY_EN to add LATENCY wait cycles per transaction.
module data_bus_responder
    import data_bus_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    data_bus_responder_if.slave   bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (LATENCY > 1024)) begin : g_bad_cfg
        $error("data_bus_responder: DEPTH must be a power of two >= 2 and LATENCY <= 1024");
    end

`ifdef DATA_BUS_RESPONDER_LATENCY_EN
    localparam int unsigned CNT_W = (LATENCY == 0) ? 1 : $clog2(LATENCY + 1);
    logic [CNT_W-1:0] r_cnt, r_cnt_d;
    logic [CNT_W-1:0] w_cnt, w_cnt_d;
`endif

    read_state_t  r_state, r_state_d;
    write_state_t w_state, w_state_d;

    logic dr_addr_ready_q, dr_addr_ready_d;
    logic dr_data_valid_q, dr_data_valid_d;
    logic dw_ready_q, dw_ready_d;
    logic dw_resp_valid_q, dw_resp_valid_d;
    logic [BUS_RESP_WIDTH-1:0] dw_resp_q, dw_resp_d;

    logic rd_accept_c, rd_in_range_c;
    logic wr_accept_c, wr_ok_c;
    logic [BUS_WIDTH-1:0] rd_data;
    dw_req_t wr_req;

    assign wr_req        = '{addr: bus.dw_addr, data: bus.dw_data};
    assign rd_accept_c   = bus.dr_addr_valid & dr_addr_ready_q;
    assign wr_accept_c   = bus.dw_data_addr_valid & dw_ready_q;
    assign rd_in_range_c = addr_in_range(bus.dr_addr, DEPTH);
    assign wr_ok_c       = addr_in_range(wr_req.addr, DEPTH) && (wr_req.addr[1:0] == 2'b00);

    // Read channel next state and registered outputs.
    always_comb begin
        r_state_d       = r_state;
        dr_addr_ready_d = 1'b0;
        dr_data_valid_d = 1'b0;
`ifdef DATA_BUS_RESPONDER_LATENCY_EN
        r_cnt_d         = r_cnt;
`endif
        unique case (r_state)
            R_IDLE: begin
                if (rd_accept_c) begin
`ifdef DATA_BUS_RESPONDER_LATENCY_EN
                    if (LATENCY != 0) begin
                        r_state_d = R_WAIT;
                        r_cnt_d   = CNT_W'(LATENCY);
                    end else begin
                        r_state_d = R_DATA;
                    end
`else
                    r_state_d = R_DATA;
`endif
                end
            end
            R_WAIT: begin
`ifdef DATA_BUS_RESPONDER_LATENCY_EN
                if (r_cnt <= CNT_W'(1)) begin
                    r_state_d = R_DATA;
                    r_cnt_d   = '0;
                end else begin
                    r_cnt_d   = r_cnt - CNT_W'(1);
                end
`else
                r_state_d = R_IDLE;
`endif
            end
            R_DATA: begin
                if (dr_data_valid_q && bus.dr_data_ready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (r_state_d == R_IDLE) dr_addr_ready_d = 1'b1;
        if (r_state_d == R_DATA) dr_data_valid_d = 1'b1;
    end

    // Write channel next state; response code is captured on acceptance.
    always_comb begin
        w_state_d       = w_state;
        dw_ready_d      = 1'b0;
        dw_resp_valid_d = 1'b0;
        dw_resp_d       = dw_resp_q;
`ifdef DATA_BUS_RESPONDER_LATENCY_EN
        w_cnt_d         = w_cnt;
`endif
        unique case (w_state)
            W_IDLE: begin
                if (wr_accept_c) begin
                    dw_resp_d = wr_ok_c ? DATA_WRITE_RESP_OK : DATA_WRITE_RESP_FAIL;
`ifdef DATA_BUS_RESPONDER_LATENCY_EN
                    if (LATENCY != 0) begin
                        w_state_d = W_WAIT;
                        w_cnt_d   = CNT_W'(LATENCY);
                    end else begin
                        w_state_d = W_RESP;
                    end
`else
                    w_state_d = W_RESP;
`endif
                end
            end
            W_WAIT: begin
`ifdef DATA_BUS_RESPONDER_LATENCY_EN
                if (w_cnt <= CNT_W'(1)) begin
                    w_state_d = W_RESP;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d   = w_cnt - CNT_W'(1);
                end
`else
                w_state_d = W_IDLE;
`endif
            end
            W_RESP: begin
                if (dw_resp_valid_q && bus.dw_resp_ready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        if (w_state_d == W_IDLE) dw_ready_d      = 1'b1;
        if (w_state_d == W_RESP) dw_resp_valid_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= R_IDLE;
            w_state         <= W_IDLE;
            dr_addr_ready_q <= 1'b0;
            dr_data_valid_q <= 1'b0;
            dw_ready_q      <= 1'b0;
            dw_resp_valid_q <= 1'b0;
            dw_resp_q       <= DATA_WRITE_RESP_FAIL;
`ifdef DATA_BUS_RESPONDER_LATENCY_EN
            r_cnt           <= '0;
            w_cnt           <= '0;
`endif
        end else begin
            r_state         <= r_state_d;
            w_state         <= w_state_d;
            dr_addr_ready_q <= dr_addr_ready_d;
            dr_data_valid_q <= dr_data_valid_d;
            dw_ready_q      <= dw_ready_d;
            dw_resp_valid_q <= dw_resp_valid_d;
            dw_resp_q       <= dw_resp_d;
`ifdef DATA_BUS_RESPONDER_LATENCY_EN
            r_cnt           <= r_cnt_d;
            w_cnt           <= w_cnt_d;
`endif
        end
    end

    // Reads sample the array on acceptance so a same-edge write is not visible.
    data_bus_responder_mem #(
        .DEPTH (DEPTH),
        .WIDTH (BUS_WIDTH)
    ) u_responder_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_accept_c & wr_ok_c),
        .wr_idx  (wr_req.addr[2 +: IDX_W]),
        .wr_data (wr_req.data),
        .rd_en   (rd_accept_c),
        .rd_zero (~rd_in_range_c),
        .rd_idx  (bus.dr_addr[2 +: IDX_W]),
        .rd_data (rd_data)
    );

    assign bus.dr_addr_ready      = dr_addr_ready_q;
    assign bus.dr_data_valid      = dr_data_valid_q;
    assign bus.dr_data            = rd_data;
    assign bus.dw_data_addr_ready = dw_ready_q;
    assign bus.dw_resp_valid      = dw_resp_valid_q;
    assign bus.dw_resp            = dw_resp_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// Bench for data_bus_responder: directed transactions against a word-array reference model.
module tb_data_bus_responder;
    import data_bus_responder_pkg::*;

`ifdef DATA_BUS_RESPONDER_LATENCY_EN
    localparam int unsigned LAT = 3;
`else
    localparam int unsigned LAT = 0;
`endif
    localparam int unsigned DEPTH = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_bus_responder_if bus();

    data_bus_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void check1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: word array plus one pending transaction per channel.
    logic [31:0] mdl_mem [DEPTH];
    logic        mdl_wr  [DEPTH];
    int   cyc = 0;
    logic alive = 1'b0, rd_pend = 1'b0, wr_pend = 1'b0;
    int   rd_due = 0, wr_due = 0;
    logic [31:0] rd_exp = '0;
    logic rd_known = 1'b0;
    logic wr_exp = 1'b0;

    initial for (int i = 0; i < int'(DEPTH); i++) mdl_wr[i] = 1'b0;

    function automatic logic in_range(input logic [31:0] a);
        return (a / 4) < DEPTH;
    endfunction

    function automatic logic exp_rd_ready();  return alive && !rd_pend;               endfunction
    function automatic logic exp_wr_ready();  return alive && !wr_pend;               endfunction
    function automatic logic exp_rd_valid();  return rd_pend && (cyc >= rd_due);      endfunction
    function automatic logic exp_wr_valid();  return wr_pend && (cyc >= wr_due);      endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            alive   <= 1'b0;
            rd_pend <= 1'b0;
            wr_pend <= 1'b0;
        end else begin
            alive <= 1'b1;
            cyc   <= cyc + 1;
            if (exp_rd_valid() && bus.dr_data_ready) rd_pend <= 1'b0;
            if (exp_wr_valid() && bus.dw_resp_ready) wr_pend <= 1'b0;
            if (exp_rd_ready() && bus.dr_addr_valid) begin
                rd_pend <= 1'b1;
                rd_due  <= cyc + 1 + int'(LAT);
                if (!in_range(bus.dr_addr)) begin
                    rd_known <= 1'b1;
                    rd_exp   <= '0;
                end else begin
                    rd_known <= mdl_wr[int'(bus.dr_addr / 4)];
                    rd_exp   <= mdl_mem[int'(bus.dr_addr / 4)];
                end
            end
            if (exp_wr_ready() && bus.dw_data_addr_valid) begin
                wr_pend <= 1'b1;
                wr_due  <= cyc + 1 + int'(LAT);
                wr_exp  <= in_range(bus.dw_addr) && (bus.dw_addr % 4 == 0);
                if (in_range(bus.dw_addr) && (bus.dw_addr % 4 == 0)) begin
                    mdl_mem[int'(bus.dw_addr / 4)] <= bus.dw_data;
                    mdl_wr[int'(bus.dw_addr / 4)]  <= 1'b1;
                end
            end
        end
    end

    // Every cycle: outputs must match the model (all zero while in reset).
    always @(negedge clk) begin
        if (!rst) begin
            check1 ("rst_dr_addr_ready", bus.dr_addr_ready, 1'b0);
            check1 ("rst_dr_data_valid", bus.dr_data_valid, 1'b0);
            check32("rst_dr_data", bus.dr_data, 32'h0);
            check1 ("rst_dw_ready", bus.dw_data_addr_ready, 1'b0);
            check1 ("rst_dw_resp_valid", bus.dw_resp_valid, 1'b0);
            check1 ("rst_dw_resp", bus.dw_resp, 1'b0);
        end else begin
            check1("dr_addr_ready", bus.dr_addr_ready, exp_rd_ready());
            check1("dr_data_valid", bus.dr_data_valid, exp_rd_valid());
            if (exp_rd_valid() && rd_known) check32("dr_data", bus.dr_data, rd_exp);
            check1("dw_data_addr_ready", bus.dw_data_addr_ready, exp_wr_ready());
            check1("dw_resp_valid", bus.dw_resp_valid, exp_wr_valid());
            if (exp_wr_valid()) check1("dw_resp", bus.dw_resp, wr_exp);
        end
    end

    // Called at a negedge; returns at a negedge after the response transfer.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input int stall, input logic exp);
        int n;
        bus.dw_data_addr_valid = 1'b1;
        bus.dw_addr            = a;
        bus.dw_data            = d;
        bus.dw_resp_ready      = (stall == 0);
        n = 0;
        while (!bus.dw_data_addr_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check1("wr_accept_timeout", 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.dw_data_addr_valid = 1'b0;
        n = 1;
        while (!bus.dw_resp_valid && n < 50) begin @(negedge clk); n++; end
        check32("wr_latency", 32'(n), 32'(1 + LAT));
        repeat (stall) @(negedge clk);
        check1("wr_resp", bus.dw_resp, exp);
        bus.dw_resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.dw_resp_ready = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input int stall, input logic [31:0] exp, output longint acc);
        int n;
        bus.dr_addr_valid = 1'b1;
        bus.dr_addr       = a;
        bus.dr_data_ready = (stall == 0);
        n = 0;
        while (!bus.dr_addr_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check1("rd_accept_timeout", 1'b0, 1'b1);
        @(posedge clk);
        acc = longint'($time);
        @(negedge clk);
        bus.dr_addr_valid = 1'b0;
        n = 1;
        while (!bus.dr_data_valid && n < 50) begin @(negedge clk); n++; end
        check32("rd_latency", 32'(n), 32'(1 + LAT));
        repeat (stall) @(negedge clk);
        check32("rd_data", bus.dr_data, exp);
        bus.dr_data_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.dr_data_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        longint t0, t1, t2;
        bus.dr_addr_valid = 1'b0; bus.dr_addr = '0; bus.dr_data_ready = 1'b0;
        bus.dw_data_addr_valid = 1'b0; bus.dw_addr = '0; bus.dw_data = '0; bus.dw_resp_ready = 1'b0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check1("ready_before_first_edge", bus.dr_addr_ready, 1'b0);
        @(negedge clk);
        check1("rd_ready_first_edge", bus.dr_addr_ready, 1'b1);
        check1("wr_ready_first_edge", bus.dw_data_addr_ready, 1'b1);

        wr(32'h10, 32'hCAFEBABE, 0, DATA_WRITE_RESP_OK);
        rd(32'h10, 0, 32'hCAFEBABE, t0);

        // Out of range: 0x1000 aliases word 0 in the index bits but must not write it.
        wr(32'h0, 32'h11111111, 0, DATA_WRITE_RESP_OK);
        wr(32'h1000, 32'hDEADBEEF, 0, DATA_WRITE_RESP_FAIL);
        rd(32'h1000, 0, 32'h0, t0);
        rd(32'h0, 0, 32'h11111111, t0);

        wr(32'h13, 32'h12345678, 0, DATA_WRITE_RESP_FAIL);
        rd(32'h13, 0, 32'hCAFEBABE, t0);

        wr(32'h20, 32'h1, 0, DATA_WRITE_RESP_OK);
        fork
            wr(32'h24, 32'hA5A5A5A5, 5, DATA_WRITE_RESP_OK);
            rd(32'h10, 5, 32'hCAFEBABE, t0);
        join

        // Same-edge read and write of one word: read sees the old value.
        fork
            wr(32'h20, 32'h2, 0, DATA_WRITE_RESP_OK);
            rd(32'h20, 0, 32'h1, t0);
        join
        rd(32'h20, 0, 32'h2, t1);
        rd(32'h24, 0, 32'hA5A5A5A5, t2);
        check32("read_throughput_cycles", 32'((t2 - t1) / 10), 32'(2 + LAT));

        // Reset while both channels hold an accepted transaction.
        bus.dr_addr_valid = 1'b1; bus.dr_addr = 32'h10; bus.dr_data_ready = 1'b0;
        bus.dw_data_addr_valid = 1'b1; bus.dw_addr = 32'h44; bus.dw_data = 32'h77; bus.dw_resp_ready = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        bus.dr_addr_valid = 1'b0;
        bus.dw_data_addr_valid = 1'b0;
        #1;
        check1 ("midrst_dr_addr_ready", bus.dr_addr_ready, 1'b0);
        check1 ("midrst_dr_data_valid", bus.dr_data_valid, 1'b0);
        check32("midrst_dr_data", bus.dr_data, 32'h0);
        check1 ("midrst_dw_ready", bus.dw_data_addr_ready, 1'b0);
        check1 ("midrst_dw_resp_valid", bus.dw_resp_valid, 1'b0);
        check1 ("midrst_dw_resp", bus.dw_resp, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check1("rd_ready_after_midrst", bus.dr_addr_ready, 1'b1);
        check1("wr_ready_after_midrst", bus.dw_data_addr_ready, 1'b1);
        rd(32'h44, 0, 32'h77, t0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
